// File: rtl/dual_port_ram_ctl.sv
// ---------------------------------------------------------------------------
// dual_port_ram_ctl
// Parametrised true dual-port synchronous RAM. Each port independently reads
// or writes every cycle, with a registered read-data path and a read-valid
// strobe that pulses once per enabled access (reads and writes alike).
//
// Optional build macro: MEM_CLEAR_EN
//   When defined, reset starts a clear sequencer that writes zero to every
//   word (one per cycle, through the port A write path). busy is high while
//   it runs, and both ports are ignored during that time. When undefined,
//   busy is tied low and the storage powers up with undefined contents.
//
// Parameters
//   DATA_W    word width
//   ADDR_W    address width
//   DEPTH     number of words (<= 2**ADDR_W)
//   READ_MODE same-port read-during-write: 0 old data, 1 new data
//   OUT_REG   1 adds one output pipeline stage to both ports
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   en_x, we_x, addr_x, din_x  port x access enable, write enable, address,
//                              write data (x = a, b)
//   dout_x, vld_x              port x read data and its valid strobe
//   collision                  pulse: both ports wrote the same address
//   oor_err                    pulse: an enabled access had addr >= DEPTH
//   busy                       clear sequencer active, ports ignored
// ---------------------------------------------------------------------------
module dual_port_ram_ctl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 32,
  parameter int READ_MODE = 0,
  parameter int OUT_REG   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  output logic              vld_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              vld_b,
  output logic              collision,
  output logic              oor_err,
  output logic              busy
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              busy_s;
  logic              acc_a_s, acc_b_s;
  logic              inr_a_s, inr_b_s;
  logic              wr_a_s, wr_b_s;
  logic              coll_s, oor_s;
  logic [DATA_W-1:0] rd_a_s, rd_b_s;
  logic              mwe_a_s;
  logic [ADDR_W-1:0] maddr_a_s;
  logic [DATA_W-1:0] mdata_a_s;

  logic [DATA_W-1:0] dout1_a_r, dout1_b_r;
  logic              vld1_a_r, vld1_b_r;
  logic              coll1_r, oor1_r;

`ifdef MEM_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic              busy_r;

  // Clear sequencer: reset lands in CLEAR, walks addresses 0..DEPTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= CLEAR;
      clr_cnt_r <= '0;
      busy_r    <= 1'b1;
    end else begin
      case (state_r)
        CLEAR: begin
          if (clr_cnt_r == LAST_ADDR) begin
            state_r   <= IDLE;
            clr_cnt_r <= '0;
            busy_r    <= 1'b0;
          end else begin
            clr_cnt_r <= clr_cnt_r + ADDR_W'(1'b1);
            busy_r    <= 1'b1;
          end
        end
        IDLE: begin
          busy_r <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          clr_cnt_r <= '0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign busy_s = busy_r;

  // Port A write path is shared with the clear sequencer.
  always_comb begin
    mwe_a_s   = wr_a_s;
    maddr_a_s = addr_a;
    mdata_a_s = din_a;
    if (state_r == CLEAR) begin
      mwe_a_s   = 1'b1;
      maddr_a_s = clr_cnt_r;
      mdata_a_s = '0;
    end else begin
      mwe_a_s   = wr_a_s;
      maddr_a_s = addr_a;
      mdata_a_s = din_a;
    end
  end
`else
  assign busy_s = 1'b0;

  // Port A write path straight from the port.
  always_comb begin
    mwe_a_s   = wr_a_s;
    maddr_a_s = addr_a;
    mdata_a_s = din_a;
  end
`endif

  assign busy = busy_s;

  // Access qualification, collision / range detection and read-data select.
  always_comb begin
    acc_a_s = en_a & ~busy_s;
    acc_b_s = en_b & ~busy_s;
    inr_a_s = ({1'b0, addr_a} < DEPTH_L);
    inr_b_s = ({1'b0, addr_b} < DEPTH_L);
    wr_a_s  = acc_a_s & we_a & inr_a_s;
    // Same-address double write: port A wins, port B is dropped.
    coll_s  = wr_a_s & acc_b_s & we_b & inr_b_s & (addr_a == addr_b);
    wr_b_s  = acc_b_s & we_b & inr_b_s & ~coll_s;
    // Both ports out of range still yields a single pulse.
    oor_s   = (acc_a_s & ~inr_a_s) | (acc_b_s & ~inr_b_s);

    // mem_r is read before this edge's writes land, so a cross-port
    // reader always sees the old word.
    if (!inr_a_s) begin
      rd_a_s = '0;
    end else if (we_a && (READ_MODE != 0)) begin
      rd_a_s = din_a;
    end else begin
      rd_a_s = mem_r[addr_a];
    end

    if (!inr_b_s) begin
      rd_b_s = '0;
    end else if (we_b && (READ_MODE != 0)) begin
      rd_b_s = din_b;
    end else begin
      rd_b_s = mem_r[addr_b];
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (mwe_a_s) begin
      mem_r[maddr_a_s] <= mdata_a_s;
    end
    if (wr_b_s) begin
      mem_r[addr_b] <= din_b;
    end
  end

  // First output stage: dout holds when the port is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout1_a_r <= '0;
      dout1_b_r <= '0;
      vld1_a_r  <= 1'b0;
      vld1_b_r  <= 1'b0;
      coll1_r   <= 1'b0;
      oor1_r    <= 1'b0;
    end else begin
      vld1_a_r <= acc_a_s;
      vld1_b_r <= acc_b_s;
      coll1_r  <= coll_s;
      oor1_r   <= oor_s;
      if (acc_a_s) begin
        dout1_a_r <= rd_a_s;
      end
      if (acc_b_s) begin
        dout1_b_r <= rd_b_s;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_pipe
      logic [DATA_W-1:0] dout2_a_r, dout2_b_r;
      logic              vld2_a_r, vld2_b_r;
      logic              coll2_r, oor2_r;

      // Second output stage; flags travel with vld to stay aligned.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout2_a_r <= '0;
          dout2_b_r <= '0;
          vld2_a_r  <= 1'b0;
          vld2_b_r  <= 1'b0;
          coll2_r   <= 1'b0;
          oor2_r    <= 1'b0;
        end else begin
          vld2_a_r <= vld1_a_r;
          vld2_b_r <= vld1_b_r;
          coll2_r  <= coll1_r;
          oor2_r   <= oor1_r;
          if (vld1_a_r) begin
            dout2_a_r <= dout1_a_r;
          end
          if (vld1_b_r) begin
            dout2_b_r <= dout1_b_r;
          end
        end
      end

      assign dout_a    = dout2_a_r;
      assign dout_b    = dout2_b_r;
      assign vld_a     = vld2_a_r;
      assign vld_b     = vld2_b_r;
      assign collision = coll2_r;
      assign oor_err   = oor2_r;
    end else begin : g_direct
      assign dout_a    = dout1_a_r;
      assign dout_b    = dout1_b_r;
      assign vld_a     = vld1_a_r;
      assign vld_b     = vld1_b_r;
      assign collision = coll1_r;
      assign oor_err   = oor1_r;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_ctl.sv
// ---------------------------------------------------------------------------
// tb_dual_port_ram_ctl
// Two instances share the same stimulus:
//   u0: DEPTH=32, READ_MODE=0, OUT_REG=0
//   u1: DEPTH=20, READ_MODE=1, OUT_REG=1 (addresses 20..31 are out of range)
// A word-level memory model computes each access's expected response and
// the cycle it must appear on; a negedge monitor pops and compares.
// Stream index k: 0 u0.A, 1 u0.B, 2 u1.A, 3 u1.B.
// Event index k:  0 u0.collision, 1 u0.oor_err, 2 u1.collision, 3 u1.oor_err.
// ---------------------------------------------------------------------------
module tb_dual_port_ram_ctl;

  localparam int DEP0 = 32;
  localparam int DEP1 = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, we_a, en_b, we_b;
  logic [4:0] addr_a, addr_b;
  logic [7:0] din_a, din_b;

  logic [7:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic       vld_a0, vld_b0, vld_a1, vld_b1;
  logic       coll0, oor0, busy0, coll1, oor1, busy1;

  always #5 clk = ~clk;

  dual_port_ram_ctl #(.DATA_W(8), .ADDR_W(5), .DEPTH(DEP0), .READ_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0), .vld_a(vld_a0),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0), .vld_b(vld_b0),
    .collision(coll0), .oor_err(oor0), .busy(busy0)
  );

  dual_port_ram_ctl #(.DATA_W(8), .ADDR_W(5), .DEPTH(DEP1), .READ_MODE(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1), .vld_a(vld_a1),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1), .vld_b(vld_b1),
    .collision(coll1), .oor_err(oor1), .busy(busy1)
  );

  logic [7:0] dout_w [4];
  logic       vld_w  [4];
  logic       ev_w   [4];
  assign dout_w[0] = dout_a0;  assign vld_w[0] = vld_a0;
  assign dout_w[1] = dout_b0;  assign vld_w[1] = vld_b0;
  assign dout_w[2] = dout_a1;  assign vld_w[2] = vld_a1;
  assign dout_w[3] = dout_b1;  assign vld_w[3] = vld_b1;
  assign ev_w[0] = coll0;  assign ev_w[1] = oor0;
  assign ev_w[2] = coll1;  assign ev_w[3] = oor1;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t       expq [4][$];
  int         evq  [4][$];
  logic [7:0] last_exp [4];
  logic [7:0] mm [2][32];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int depth_of(input int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction

  task automatic chk(input string nm, input int k, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s k=%0d cyc=%0d got=0x%0h want=0x%0h", nm, k, cyc, got, want);
    end
  endtask

  // Reference model for one instance and one clock edge.
  task automatic model_step(input int d,
                            input bit ea, input bit wa, input logic [4:0] aa, input logic [7:0] da,
                            input bit eb, input bit wb, input logic [4:0] ab, input logic [7:0] db);
    int   due;
    bit   ina, inb, write_first;
    exp_t e;
    due         = cyc + 1 + d;          // u1 has the extra output stage
    write_first = (d == 1);
    ina = int'(aa) < depth_of(d);
    inb = int'(ab) < depth_of(d);
    if (ea) begin
      e.due  = due;
      e.data = !ina ? 8'h00 : (wa && write_first) ? da : mm[d][aa];
      expq[d*2].push_back(e);
    end
    if (eb) begin
      e.due  = due;
      e.data = !inb ? 8'h00 : (wb && write_first) ? db : mm[d][ab];
      expq[d*2+1].push_back(e);
    end
    if (ea && wa && ina && eb && wb && inb && (aa == ab)) evq[d*2].push_back(due);
    if ((ea && !ina) || (eb && !inb)) evq[d*2+1].push_back(due);
    if (eb && wb && inb) mm[d][ab] = db;
    if (ea && wa && ina) mm[d][aa] = da;   // A lands last: A wins
  endtask

  task automatic drive(input bit ea, input bit wa, input logic [4:0] aa, input logic [7:0] da,
                       input bit eb, input bit wb, input logic [4:0] ab, input logic [7:0] db);
    @(negedge clk);
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    model_step(0, ea, wa, aa, da, eb, wb, ab, db);
    model_step(1, ea, wa, aa, da, eb, wb, ab, db);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic zero_inputs();
    en_a = 1'b0; we_a = 1'b0; addr_a = 5'd0; din_a = 8'h00;
    en_b = 1'b0; we_b = 1'b0; addr_b = 5'd0; din_b = 8'h00;
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 4; k++) begin
      chk("rst_dout", k, int'(dout_w[k]), 0);
      chk("rst_vld", k, int'(vld_w[k]), 0);
      chk("rst_event", k, int'(ev_w[k]), 0);
    end
`ifdef MEM_CLEAR_EN
    chk("rst_busy", 0, int'(busy0), 1);
    chk("rst_busy", 1, int'(busy1), 1);
`endif
  endtask

  // Called on the negedge where rst has just been released.
  task automatic post_reset();
`ifdef MEM_CLEAR_EN
    int n0 = 0;
    int n1 = 0;
    int g  = 0;
    while ((busy0 || busy1) && g < 100) begin
      if (busy0) n0++;
      if (busy1) n1++;
      // Attempted accesses while both instances are still clearing.
      if (g < 10) begin
        en_a = 1'b1; we_a = 1'b1; addr_a = 5'd5; din_a = 8'h77;
        en_b = 1'b1; we_b = 1'b0; addr_b = 5'd5;
      end else begin
        zero_inputs();
      end
      g++;
      @(negedge clk);
    end
    zero_inputs();
    chk("busy_len", 0, n0, DEP0);
    chk("busy_len", 1, n1, DEP1);
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++) mm[d][a] = 8'h00;
`endif
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    zero_inputs();
    rst = 1'b1;
    #1;
    check_reset_outputs();
    for (int k = 0; k < 4; k++) begin
      expq[k].delete();
      evq[k].delete();
      last_exp[k] = 8'h00;
    end
    @(negedge clk);
    rst = 1'b0;
    post_reset();
  endtask

  // Monitor: compares presented outputs with the scoreboard each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (vld_w[k]) begin
          if (expq[k].size() == 0 || expq[k][0].due != cyc) begin
            chk("vld_unexpected", k, 1, 0);
          end else begin
            exp_t e;
            e = expq[k].pop_front();
            chk("dout", k, int'(dout_w[k]), int'(e.data));
            last_exp[k] = e.data;
          end
        end else begin
          if (expq[k].size() > 0 && expq[k][0].due == cyc) begin
            exp_t e;
            e = expq[k].pop_front();
            chk("vld_missing", k, 0, 1);
            last_exp[k] = e.data;
          end else begin
            chk("dout_hold", k, int'(dout_w[k]), int'(last_exp[k]));
          end
        end
        begin
          bit ev_exp;
          ev_exp = (evq[k].size() > 0) && (evq[k][0] == cyc);
          if (ev_exp) void'(evq[k].pop_front());
          chk((k % 2 == 0) ? "collision" : "oor_err", k, int'(ev_w[k]), int'(ev_exp));
        end
      end
`ifndef MEM_CLEAR_EN
      chk("busy", 0, int'(busy0), 0);
      chk("busy", 1, int'(busy1), 0);
`endif
    end
  end

  initial begin
    bit         ea, wa, eb, wb;
    logic [4:0] aa, ab;
    for (int k = 0; k < 4; k++) last_exp[k] = 8'h00;
    zero_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    post_reset();

`ifndef MEM_CLEAR_EN
    // Storage is undefined at power-up: give every word a known value.
    for (int i = 0; i < 32; i++)
      drive(1'b1, 1'b1, 5'(i), 8'($urandom), 1'b0, 1'b0, 5'd0, 8'h00);
`endif

    // Write then cross-port read.
    drive(1'b1, 1'b1, 5'd3, 8'h5A, 1'b0, 1'b0, 5'd0, 8'h00);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd3, 8'h00);
    // Read-during-write on both ports, then readback.
    drive(1'b1, 1'b1, 5'd7, 8'h11, 1'b0, 1'b0, 5'd0, 8'h00);
    drive(1'b1, 1'b1, 5'd7, 8'h22, 1'b1, 1'b0, 5'd7, 8'h00);
    drive(1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    // Write/write collision, then readback.
    drive(1'b1, 1'b1, 5'd9, 8'hAA, 1'b1, 1'b1, 5'd9, 8'hBB);
    drive(1'b1, 1'b0, 5'd9, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    // Out of range for u1, in range for u0; then both ports out of range.
    drive(1'b1, 1'b1, 5'd25, 8'hFF, 1'b0, 1'b0, 5'd0, 8'h00);
    drive(1'b1, 1'b0, 5'd25, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    drive(1'b1, 1'b0, 5'd25, 8'h00, 1'b1, 1'b1, 5'd30, 8'h3C);
    // Back-to-back reads through the pipeline.
    for (int i = 1; i <= 3; i++)
      drive(1'b1, 1'b1, 5'(i), 8'(i), 1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 1; i <= 3; i++)
      drive(1'b1, 1'b0, 5'(i), 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    repeat (3) idle();
    // Same reads again, reset lands while data is in flight.
    for (int i = 1; i <= 3; i++)
      drive(1'b1, 1'b0, 5'(i), 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    reset_pulse();

    // Randomised traffic, biased toward a small hot address window.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) reset_pulse();
      ea = 1'($urandom_range(0, 1));
      wa = 1'($urandom_range(0, 1));
      eb = 1'($urandom_range(0, 1));
      wb = 1'($urandom_range(0, 1));
      aa = ($urandom_range(0, 2) == 0) ? 5'(8 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
      ab = ($urandom_range(0, 2) == 0) ? 5'(8 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
      drive(ea, wa, aa, 8'($urandom), eb, wb, ab, 8'($urandom));
    end

    // Full readback on both ports.
    for (int i = 0; i < 32; i++)
      drive(1'b1, 1'b0, 5'(i), 8'h00, 1'b1, 1'b0, 5'(31 - i), 8'h00);
    repeat (4) idle();

    for (int k = 0; k < 4; k++) begin
      chk("drain_data", k, expq[k].size(), 0);
      chk("drain_event", k, evq[k].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
